// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL feedback divider.
package pll_pkg;
  localparam int DIV_W_DEF     = 8;
  localparam int RESET_DIV_DEF = 50;  // 50 MHz clk_out / 1 MHz clk_ref
  localparam int MIN_DIV       = 2;   // smallest ratio that still gives a real high and low phase

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_load_ctrl.sv
// Ratio-load handshake: captures a request into a shadow register, holds it
// pending until the divider reaches a period boundary, then acknowledges.
module div_load_ctrl
  import pll_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_out,
  input  logic             n_rst,
  input  logic             i_load_req,
  input  logic [DIV_W-1:0] i_div_ratio,
  input  logic             i_boundary,    // LOW phase ending, next edge starts a period
  input  logic             i_idle_start,  // IDLE leaving for HIGH on the next edge
  output logic             o_pending,
  output logic [DIV_W-1:0] o_shadow_ratio,
  output logic             o_load_ack,
  output logic             o_load_err
);
  logic             r_pending;
  logic             r_ack;
  logic             r_err;
  logic             r_closed;  // load_req has been seen low since the last capture
  logic [DIV_W-1:0] r_shadow;

  logic w_apply;
  logic w_capture;
  logic w_valid;

  assign w_apply   = (i_boundary | i_idle_start) & r_pending;
  assign w_capture = i_load_req & ~r_pending & ~r_ack & r_closed;
  assign w_valid   = (i_div_ratio >= DIV_W'(MIN_DIV));

  // Handshake state: capture, apply at boundary, reject, and ack release.
  // Apply and capture are exclusive since capture needs pending low.
  always_ff @(posedge clk_out or negedge n_rst) begin
    if (!n_rst) begin
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_closed  <= 1'b0;
      r_shadow  <= '0;
    end else begin
      if (!i_load_req)    r_closed <= 1'b1;
      else if (w_capture) r_closed <= 1'b0;

      if (w_apply) begin
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
        r_err     <= 1'b0;
      end else if (w_capture) begin
        if (w_valid) begin
          r_shadow  <= i_div_ratio;
          r_pending <= 1'b1;
        end else begin
          r_ack <= 1'b1;
          r_err <= 1'b1;
        end
      end else if (r_ack && !i_load_req) begin
        r_ack <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  assign o_pending      = r_pending;
  assign o_shadow_ratio = r_shadow;
  assign o_load_ack     = r_ack;
  assign o_load_err     = r_err;
endmodule

// File: rtl/feedback_divider.sv
// Programmable clk_out / N divider for the PLL feedback path. Ratio changes
// take effect only at a period boundary so clk_div never glitches.
module feedback_divider
  import pll_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic             clk_out,
  input  logic             n_rst,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             load_req,
  output logic             load_ack,
  output logic             load_err,
  output logic             clk_div,
  output logic             div_pulse
);
  div_state_t       r_state;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_active;
  logic             r_clk_div;
  logic             r_pulse;

  logic             w_pending;
  logic [DIV_W-1:0] w_shadow;
  logic             w_boundary;
  logic             w_idle_start;
  logic [DIV_W-1:0] w_ratio_next;
  logic [DIV_W-1:0] w_hi_m1;
  logic [DIV_W-1:0] w_lo_m1;
  logic             w_unused_supply;

  // Supply pins carry no logic.
  assign w_unused_supply = VDD ^ VSS;

  assign w_boundary   = (r_state == LOW) & enable & (r_phase == '0);
  assign w_idle_start = (r_state == IDLE) & enable;

  // Ratio for the period about to start; a pending load wins at a boundary.
  assign w_ratio_next = w_pending ? w_shadow : r_active;
  // High phase is ceil(N/2), low phase floor(N/2); counters hold length-1.
  assign w_hi_m1 = w_ratio_next - (w_ratio_next >> 1) - DIV_W'(1);
  assign w_lo_m1 = (r_active >> 1) - DIV_W'(1);

  div_load_ctrl #(.DIV_W(DIV_W)) u_load (
    .clk_out       (clk_out),
    .n_rst         (n_rst),
    .i_load_req    (load_req),
    .i_div_ratio   (div_ratio),
    .i_boundary    (w_boundary),
    .i_idle_start  (w_idle_start),
    .o_pending     (w_pending),
    .o_shadow_ratio(w_shadow),
    .o_load_ack    (load_ack),
    .o_load_err    (load_err)
  );

  // Divider FSM: phase counter, registered clk_div and rising-edge strobe.
  always_ff @(posedge clk_out or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_active  <= DIV_W'(RESET_DIV);
      r_clk_div <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_active  <= w_ratio_next;
            r_phase   <= w_hi_m1;
            r_clk_div <= 1'b1;
            r_pulse   <= 1'b1;
            r_state   <= HIGH;
          end else begin
            r_clk_div <= 1'b0;
            r_phase   <= '0;
          end
        end
        HIGH: begin
          if (!enable) begin
            r_state   <= IDLE;
            r_clk_div <= 1'b0;
            r_phase   <= '0;
          end else if (r_phase == '0) begin
            r_state   <= LOW;
            r_phase   <= w_lo_m1;
            r_clk_div <= 1'b0;
          end else begin
            r_phase <= r_phase - DIV_W'(1);
          end
        end
        LOW: begin
          if (!enable) begin
            r_state   <= IDLE;
            r_clk_div <= 1'b0;
            r_phase   <= '0;
          end else if (r_phase == '0) begin
            r_active  <= w_ratio_next;
            r_phase   <= w_hi_m1;
            r_clk_div <= 1'b1;
            r_pulse   <= 1'b1;
            r_state   <= HIGH;
          end else begin
            r_phase <= r_phase - DIV_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_clk_div <= 1'b0;
          r_phase   <= '0;
        end
      endcase
    end
  end

  assign clk_div   = r_clk_div;
  assign div_pulse = r_pulse;
endmodule

// File: tb/tb_feedback_divider.sv
// Directed bench for feedback_divider: period/phase lengths, load handshake,
// rejects, boundary capture, idle load and reset mid-operation.
module tb_feedback_divider;
  logic       clk_out;
  logic       n_rst;
  logic       VDD;
  logic       VSS;
  logic       enable;
  logic [7:0] div_ratio;
  logic       load_req;
  logic       load_ack;
  logic       load_err;
  logic       clk_div;
  logic       div_pulse;

  int total = 0;
  int bad   = 0;

  feedback_divider #(.DIV_W(8), .RESET_DIV(50)) dut (
    .clk_out  (clk_out),
    .n_rst    (n_rst),
    .VDD      (VDD),
    .VSS      (VSS),
    .enable   (enable),
    .div_ratio(div_ratio),
    .load_req (load_req),
    .load_ack (load_ack),
    .load_err (load_err),
    .clk_div  (clk_div),
    .div_pulse(div_pulse)
  );

  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance negedges until div_pulse is seen; cyc counts the negedges taken.
  task automatic wait_pulse(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_out);
      cyc++;
    end while (!div_pulse && cyc < 2000);
    if (!div_pulse) chk("pulse_timeout", 0, 1);
  endtask

  // Start on a div_pulse negedge; measure high time and period to next pulse.
  task automatic measure(output int hi, output int per);
    hi  = 0;
    per = 0;
    do begin
      if (clk_div) hi++;
      @(negedge clk_out);
      per++;
      if (per == 1) chk("pulse_width", div_pulse, 0);
    end while (!div_pulse && per < 2000);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_out);
  endtask

  initial begin
    int c, hi, per;
    VDD = 1'b1; VSS = 1'b0;
    n_rst = 1'b0; enable = 1'b0; load_req = 1'b0; div_ratio = 8'd0;
    step(2);
    chk("rst_clk_div", clk_div, 0);
    chk("rst_pulse", div_pulse, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_err", load_err, 0);
    n_rst = 1'b1;
    step(3);
    chk("idle_clk_div", clk_div, 0);

    // Default ratio 50
    enable = 1'b1;
    wait_pulse(c);
    chk("en_latency", c, 1);
    chk("en_clk_div", clk_div, 1);
    measure(hi, per);
    chk("n50_per", per, 50);
    chk("n50_hi", hi, 25);

    // Rejected ratios 1 and 0
    div_ratio = 8'd1; load_req = 1'b1;
    step(1);
    chk("n1_ack", load_ack, 1);
    chk("n1_err", load_err, 1);
    load_req = 1'b0;
    step(1);
    chk("n1_ack_clr", load_ack, 0);
    chk("n1_err_clr", load_err, 0);
    div_ratio = 8'd0; load_req = 1'b1;
    step(1);
    chk("n0_ack", load_ack, 1);
    chk("n0_err", load_err, 1);
    load_req = 1'b0;
    step(1);
    chk("n0_ack_clr", load_ack, 0);
    wait_pulse(c);
    measure(hi, per);
    chk("rej_per", per, 50);
    chk("rej_hi", hi, 25);

    // Load 3 mid-HIGH: current period completes
    step(5);
    div_ratio = 8'd3; load_req = 1'b1;
    step(1);
    chk("n3_ack_early", load_ack, 0);
    wait_pulse(c);
    chk("n3_boundary", c, 44);
    chk("n3_ack", load_ack, 1);
    chk("n3_err", load_err, 0);
    measure(hi, per);
    chk("n3_per", per, 3);
    chk("n3_hi", hi, 2);
    chk("n3_ack_hold", load_ack, 1);
    load_req = 1'b0;
    step(1);
    chk("n3_ack_clr", load_ack, 0);

    // Load 7 sampled exactly at the boundary edge
    wait_pulse(c);
    step(2);
    div_ratio = 8'd7; load_req = 1'b1;
    step(1);
    chk("n7_old_pulse", div_pulse, 1);
    chk("n7_ack_early", load_ack, 0);
    wait_pulse(c);
    chk("n7_old_per", c, 3);
    chk("n7_ack", load_ack, 1);
    measure(hi, per);
    chk("n7_per", per, 7);
    chk("n7_hi", hi, 4);
    load_req = 1'b0;

    // Drop enable mid-HIGH, load 2 while idle, re-enable
    step(1);
    enable = 1'b0;
    step(1);
    chk("dis_clk_div", clk_div, 0);
    chk("dis_ack", load_ack, 0);
    div_ratio = 8'd2; load_req = 1'b1;
    step(2);
    chk("idle_ack", load_ack, 0);
    chk("idle_clk_div2", clk_div, 0);
    enable = 1'b1;
    step(1);
    chk("reen_clk_div", clk_div, 1);
    chk("reen_pulse", div_pulse, 1);
    chk("reen_ack", load_ack, 1);
    measure(hi, per);
    chk("n2_per", per, 2);
    chk("n2_hi", hi, 1);
    load_req = 1'b0;
    measure(hi, per);
    chk("n2_per2", per, 2);
    chk("n2_ack_clr", load_ack, 0);

    // Move to 10, then reset mid-LOW with a load of 4 pending
    div_ratio = 8'd10; load_req = 1'b1;
    wait_pulse(c);
    chk("n10_lat", c, 2);
    chk("n10_ack", load_ack, 1);
    measure(hi, per);
    chk("n10_per", per, 10);
    chk("n10_hi", hi, 5);
    load_req = 1'b0;
    step(1);
    div_ratio = 8'd4; load_req = 1'b1;
    step(5);
    chk("pend_low", clk_div, 0);
    chk("pend_ack", load_ack, 0);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_clk_div", clk_div, 0);
    chk("mid_rst_pulse", div_pulse, 0);
    chk("mid_rst_ack", load_ack, 0);
    load_req = 1'b0;
    step(1);
    n_rst = 1'b1;
    wait_pulse(c);
    chk("post_rst_lat", c, 1);
    measure(hi, per);
    chk("post_rst_per", per, 50);
    chk("post_rst_hi", hi, 25);
    chk("post_rst_ack", load_ack, 0);

    // Largest ratio 255: high 128, low 127
    div_ratio = 8'd255; load_req = 1'b1;
    wait_pulse(c);
    chk("n255_lat", c, 50);
    chk("n255_ack", load_ack, 1);
    load_req = 1'b0;
    measure(hi, per);
    chk("n255_per", per, 255);
    chk("n255_hi", hi, 128);
    chk("n255_ack_clr", load_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
